// File: rtl/stopwatch_pkg.sv
// Shared constants for the stopwatch minutes:seconds counting path.
package stopwatch_pkg;

  localparam int TIME_W = 6;
  localparam logic [TIME_W-1:0] SEC_MAX = 6'd59;
  localparam logic [TIME_W-1:0] MIN_MAX = 6'd59;

endpackage

// File: rtl/second_tick_gen.sv
// Free-running prescaler: one-cycle tick every CLKS_PER_SEC clocks, frozen while hold_count is high.
module second_tick_gen #(
  parameter int CLKS_PER_SEC = 50_000_000
) (
  input  logic clock,
  input  logic reset,
  input  logic hold_count,
  output logic tick
);

  localparam int DIV_W = (CLKS_PER_SEC > 1) ? $clog2(CLKS_PER_SEC) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLKS_PER_SEC - 1);

  logic [DIV_W-1:0] div_q, div_d;

  assign tick = !hold_count && (div_q == DIV_LAST);

  // Holding keeps the partial second so a resume finishes the same second.
  always_comb begin
    div_d = div_q;
    if (tick) begin
      div_d = '0;
    end else if (!hold_count) begin
      div_d = div_q + DIV_W'(1);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      div_q <= '0;
    end else begin
      div_q <= div_d;
    end
  end

endmodule

// File: rtl/stopwatch_time_counter.sv
// Minutes:seconds cascade driven by a one-second tick; wraps at 59:59 by default,
// or saturates at 59:59 when TIME_COUNTER_SATURATE_EN is defined.
module stopwatch_time_counter
  import stopwatch_pkg::*;
#(
  parameter int CLKS_PER_SEC = 50_000_000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              hold_count,
  output logic [TIME_W-1:0] minutes,
  output logic [TIME_W-1:0] seconds
);

  logic              tick;
  logic [TIME_W-1:0] sec_q, sec_d;
  logic [TIME_W-1:0] min_q, min_d;

  second_tick_gen #(
    .CLKS_PER_SEC(CLKS_PER_SEC)
  ) u_tick (
    .clock      (clock),
    .reset      (reset),
    .hold_count (hold_count),
    .tick       (tick)
  );

  always_comb begin
    sec_d = sec_q;
    min_d = min_q;
    if (tick) begin
      if (sec_q == SEC_MAX) begin
        if (min_q == MIN_MAX) begin
`ifdef TIME_COUNTER_SATURATE_EN
          sec_d = sec_q;
          min_d = min_q;
`else
          sec_d = '0;
          min_d = '0;
`endif
        end else begin
          sec_d = '0;
          min_d = min_q + TIME_W'(1);
        end
      end else begin
        sec_d = sec_q + TIME_W'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sec_q <= '0;
      min_q <= '0;
    end else begin
      sec_q <= sec_d;
      min_q <= min_d;
    end
  end

  assign minutes = min_q;
  assign seconds = sec_q;

endmodule

// File: tb/tb_stopwatch_time_counter.sv
// Directed bench for stopwatch_time_counter with CLKS_PER_SEC = 4.
module tb_stopwatch_time_counter;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       hold_count = 1'b0;
  logic [5:0] minutes;
  logic [5:0] seconds;

  int n_cmp = 0;
  int n_err = 0;

  stopwatch_time_counter #(.CLKS_PER_SEC(4)) dut (
    .clock      (clock),
    .reset      (reset),
    .hold_count (hold_count),
    .minutes    (minutes),
    .seconds    (seconds)
  );

  always #5 clock = ~clock;

  // All stimulus changes happen at falling edges; step(n) lets n rising edges pass.
  task automatic step(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b0;
    hold_count = 1'b0;
    step(2);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    hold_count = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      n_cmp++;
      if (minutes !== 6'd0 || seconds !== 6'd0) begin
        n_err++;
        $display("FAIL reset_hold_low cycle %0d: got %0d:%0d want 0:0", i, minutes, seconds);
      end
    end
    reset = 1'b1;
    step(3);
    n_cmp++;
    if (seconds !== 6'd0) begin
      n_err++;
      $display("FAIL first_tick_edge3: got sec %0d want 0", seconds);
    end
    step(1);
    n_cmp++;
    if (seconds !== 6'd1 || minutes !== 6'd0) begin
      n_err++;
      $display("FAIL first_tick_edge4: got %0d:%0d want 0:1", minutes, seconds);
    end
    step(4);
    n_cmp++;
    if (seconds !== 6'd2 || minutes !== 6'd0) begin
      n_err++;
      $display("FAIL second_tick_edge8: got %0d:%0d want 0:2", minutes, seconds);
    end
  endtask

  task automatic test_minute_rollover();
    do_reset();
    step(239);
    n_cmp++;
    if (minutes !== 6'd0 || seconds !== 6'd59) begin
      n_err++;
      $display("FAIL rollover_edge239: got %0d:%0d want 0:59", minutes, seconds);
    end
    step(1);
    n_cmp++;
    if (minutes !== 6'd1 || seconds !== 6'd0) begin
      n_err++;
      $display("FAIL rollover_edge240: got %0d:%0d want 1:0", minutes, seconds);
    end
  endtask

  task automatic test_top_of_range();
    do_reset();
    step(14396);
    n_cmp++;
    if (minutes !== 6'd59 || seconds !== 6'd59) begin
      n_err++;
      $display("FAIL preload_5959: got %0d:%0d want 59:59", minutes, seconds);
    end
    step(4);
`ifdef TIME_COUNTER_SATURATE_EN
    n_cmp++;
    if (minutes !== 6'd59 || seconds !== 6'd59) begin
      n_err++;
      $display("FAIL saturate_first: got %0d:%0d want 59:59", minutes, seconds);
    end
    step(40);
    n_cmp++;
    if (minutes !== 6'd59 || seconds !== 6'd59) begin
      n_err++;
      $display("FAIL saturate_stays: got %0d:%0d want 59:59", minutes, seconds);
    end
`else
    n_cmp++;
    if (minutes !== 6'd0 || seconds !== 6'd0) begin
      n_err++;
      $display("FAIL wrap_0000: got %0d:%0d want 0:0", minutes, seconds);
    end
    step(4);
    n_cmp++;
    if (minutes !== 6'd0 || seconds !== 6'd1) begin
      n_err++;
      $display("FAIL wrap_continue: got %0d:%0d want 0:1", minutes, seconds);
    end
`endif
  endtask

  task automatic test_hold();
    do_reset();
    step(45 * 4 + 2);
    n_cmp++;
    if (minutes !== 6'd0 || seconds !== 6'd45 || dut.u_tick.div_q !== 2'd2) begin
      n_err++;
      $display("FAIL hold_setup: got %0d:%0d div %0d want 0:45 div 2",
               minutes, seconds, dut.u_tick.div_q);
    end
    hold_count = 1'b1;
    step(40);
    n_cmp++;
    if (minutes !== 6'd0 || seconds !== 6'd45 || dut.u_tick.div_q !== 2'd2) begin
      n_err++;
      $display("FAIL hold_frozen: got %0d:%0d div %0d want 0:45 div 2",
               minutes, seconds, dut.u_tick.div_q);
    end
    hold_count = 1'b0;
    step(1);
    n_cmp++;
    if (seconds !== 6'd45) begin
      n_err++;
      $display("FAIL hold_resume_edge1: got sec %0d want 45", seconds);
    end
    step(1);
    n_cmp++;
    if (seconds !== 6'd46 || minutes !== 6'd0) begin
      n_err++;
      $display("FAIL hold_resume_edge2: got %0d:%0d want 0:46", minutes, seconds);
    end
  endtask

  task automatic test_hold_at_tick();
    do_reset();
    step(3);
    hold_count = 1'b1;
    step(5);
    n_cmp++;
    if (seconds !== 6'd0) begin
      n_err++;
      $display("FAIL hold_suppresses_tick: got sec %0d want 0", seconds);
    end
    hold_count = 1'b0;
    step(1);
    n_cmp++;
    if (seconds !== 6'd1) begin
      n_err++;
      $display("FAIL hold_tick_resume: got sec %0d want 1", seconds);
    end
  endtask

  task automatic test_reset_during_hold();
    do_reset();
    step(45 * 4);
    n_cmp++;
    if (minutes !== 6'd0 || seconds !== 6'd45) begin
      n_err++;
      $display("FAIL rst_hold_setup: got %0d:%0d want 0:45", minutes, seconds);
    end
    hold_count = 1'b1;
    @(posedge clock);
    #2;
    reset = 1'b0;
    #1;
    n_cmp++;
    if (minutes !== 6'd0 || seconds !== 6'd0) begin
      n_err++;
      $display("FAIL rst_async_clear: got %0d:%0d want 0:0", minutes, seconds);
    end
    step(3);
    reset = 1'b1;
    hold_count = 1'b0;
    step(3);
    n_cmp++;
    if (minutes !== 6'd0 || seconds !== 6'd0) begin
      n_err++;
      $display("FAIL rst_release_edge3: got %0d:%0d want 0:0", minutes, seconds);
    end
    step(1);
    n_cmp++;
    if (minutes !== 6'd0 || seconds !== 6'd1) begin
      n_err++;
      $display("FAIL rst_release_edge4: got %0d:%0d want 0:1", minutes, seconds);
    end
  endtask

  initial begin
    test_reset();
    test_minute_rollover();
    test_top_of_range();
    test_hold();
    test_hold_at_tick();
    test_reset_during_hold();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
